// File: rtl/snake_pkg.sv
// Shared encodings for the snake game: movement directions and game-state FSM.
// Imported by the input controller and by the movement stage.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_DOWN  = 2'b01,
        DIR_LEFT  = 2'b10,
        DIR_RIGHT = 2'b11
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10
    } game_state_t;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    // A direction and its reverse share bit 1, so one compare rejects both.
    function automatic logic same_axis(dir_t a, dir_t b);
        return a[1] == b[1];
    endfunction

endpackage

// File: rtl/dir_input_ctrl_if.sv
// Button/step inputs and committed-direction outputs of the direction input controller.
interface dir_input_ctrl_if;
    logic       step;
    logic       start;
    logic       btnUp;
    logic       btnDown;
    logic       btnLeft;
    logic       btnRight;
    logic [1:0] dir;
    logic       dirStrobe;
    logic       lock;

    modport master (
        output step, start, btnUp, btnDown, btnLeft, btnRight,
        input  dir, dirStrobe, lock
    );

    modport slave (
        input  step, start, btnUp, btnDown, btnLeft, btnRight,
        output dir, dirStrobe, lock
    );
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer, consecutive-cycle debouncer and rising-edge detector
// for one raw push button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic          stable;
    logic          stable_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_q <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_q <= stable;
            // Any agreeing cycle restarts the run of disagreeing cycles.
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign press = stable & ~stable_q;

endmodule

// File: rtl/dir_input_ctrl.sv
// Game start/pause FSM plus direction arbitration, pending buffer and step commit.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for first start press
//   ST_RUN   | game running; direction presses accepted, steps commit
//   ST_PAUSE | paused; presses ignored, pending dropped, lock held
module dir_input_ctrl
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    dir_input_ctrl_if.slave  bus
);

    logic [4:0]  raw;
    logic [4:0]  press;
    game_state_t state_q;
    game_state_t state_d;
    logic        lock;
    logic        run;
    dir_t        dir_q;
    dir_t        pending;
    logic        pending_valid;
    logic        strobe_q;
    dir_t        winner;
    dir_t        dir_after;
    logic        commit;
    logic        accept;
    logic        leaving;

    assign raw = {bus.start, bus.btnRight, bus.btnLeft, bus.btnDown, bus.btnUp};

    for (genvar i = 0; i < 5; i++) begin : g_btn
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn (
            .clk   (clk),
            .reset (reset),
            .raw   (raw[i]),
            .press (press[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (press[4]) begin
            case (state_q)
                ST_IDLE:  state_d = ST_RUN;
                ST_RUN:   state_d = ST_PAUSE;
                ST_PAUSE: state_d = ST_RUN;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        lock = (state_q != ST_RUN);
    end

    assign run = ~lock;

    always_comb begin
        winner = DIR_RIGHT;
        if      (press[0]) winner = DIR_UP;
        else if (press[1]) winner = DIR_DOWN;
        else if (press[2]) winner = DIR_LEFT;
    end

    // A press in the same cycle as a commit is judged against the new direction.
    assign commit    = run & bus.step & pending_valid;
    assign dir_after = commit ? pending : dir_q;
    assign accept    = run & (|press[3:0]) & ~same_axis(winner, dir_after);
    assign leaving   = run & (state_d != ST_RUN);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dir_q         <= DIR_RESET;
            pending       <= DIR_UP;
            pending_valid <= 1'b0;
            strobe_q      <= 1'b0;
        end else begin
            strobe_q <= commit;
            if (commit) dir_q <= pending;
            if (leaving) begin
                pending_valid <= 1'b0;
            end else if (accept) begin
                pending       <= winner;
                pending_valid <= 1'b1;
            end else if (commit) begin
                pending_valid <= 1'b0;
            end
        end
    end

    assign bus.dir       = dir_q;
    assign bus.dirStrobe = strobe_q;
    assign bus.lock      = lock;

endmodule

// File: tb/tb_dir_input_ctrl.sv
// Directed bench for dir_input_ctrl with DEBOUNCE_CYCLES = 4: a table of direction
// presses/steps with expected outcomes, plus hand-written multi-cycle sequences.
module tb_dir_input_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    dir_input_ctrl_if bus_if ();

    dir_input_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // btns bit order: {up, down, left, right}
    typedef struct {
        logic [3:0] btns;
        logic       do_step;
        logic [1:0] exp_dir;
        int         exp_strobes;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic set_btns(input logic [3:0] b);
        bus_if.btnUp    = b[3];
        bus_if.btnDown  = b[2];
        bus_if.btnLeft  = b[1];
        bus_if.btnRight = b[0];
    endtask

    task automatic apply_dirs(input logic [3:0] b);
        set_btns(b);
        repeat (10) @(negedge clk);
        set_btns(4'b0000);
        repeat (10) @(negedge clk);
    endtask

    task automatic press_start();
        bus_if.start = 1'b1;
        repeat (10) @(negedge clk);
        bus_if.start = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Called at a falling edge; pulses step for one cycle and counts strobes after it.
    task automatic do_step(output int strobes);
        strobes = 0;
        bus_if.step = 1'b1;
        @(negedge clk);
        bus_if.step = 1'b0;
        if (bus_if.dirStrobe) strobes++;
        repeat (3) begin
            @(negedge clk);
            if (bus_if.dirStrobe) strobes++;
        end
    endtask

    initial begin
        int lock_edge;
        int cnt;
        int total;

        n_checks = 0;
        n_fail   = 0;

        vecs[0]  = '{4'b0010, 1'b1, 2'd3, 0};
        vecs[1]  = '{4'b0001, 1'b1, 2'd3, 0};
        vecs[2]  = '{4'b0110, 1'b1, 2'd1, 1};
        vecs[3]  = '{4'b1000, 1'b1, 2'd1, 0};
        vecs[4]  = '{4'b0010, 1'b1, 2'd2, 1};
        vecs[5]  = '{4'b1111, 1'b1, 2'd0, 1};
        vecs[6]  = '{4'b0000, 1'b1, 2'd0, 0};
        vecs[7]  = '{4'b0001, 1'b1, 2'd3, 1};
        vecs[8]  = '{4'b0101, 1'b1, 2'd1, 1};
        vecs[9]  = '{4'b0010, 1'b0, 2'd1, 0};
        vecs[10] = '{4'b0000, 1'b1, 2'd2, 1};
        vecs[11] = '{4'b0100, 1'b1, 2'd1, 1};
        vecs[12] = '{4'b0001, 1'b1, 2'd3, 1};

        reset        = 1'b1;
        bus_if.step  = 1'b0;
        bus_if.start = 1'b0;
        set_btns(4'b0000);
        #1;
        check("reset_dir", int'(bus_if.dir), 3);
        check("reset_lock", int'(bus_if.lock), 1);
        check("reset_strobe", int'(bus_if.dirStrobe), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_lock", int'(bus_if.lock), 1);
        check("idle_dir", int'(bus_if.dir), 3);

        // Start latency: 2 sync + 4 debounce + 1 FSM edge.
        lock_edge = 0;
        bus_if.start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (bus_if.lock == 1'b0 && lock_edge == 0) lock_edge = k;
        end
        bus_if.start = 1'b0;
        check("start_latency", lock_edge, 7);
        repeat (10) @(negedge clk);
        check("run_lock", int'(bus_if.lock), 0);
        check("run_dir", int'(bus_if.dir), 3);

        for (int i = 0; i < 13; i++) begin
            apply_dirs(vecs[i].btns);
            cnt = 0;
            if (vecs[i].do_step) do_step(cnt);
            check($sformatf("vec%0d_dir", i), int'(bus_if.dir), int'(vecs[i].exp_dir));
            check($sformatf("vec%0d_strobes", i), cnt, vecs[i].exp_strobes);
            check($sformatf("vec%0d_lock", i), int'(bus_if.lock), 0);
        end

        // Up held across several steps: exactly one change and one strobe.
        total = 0;
        bus_if.btnUp = 1'b1;
        for (int s = 0; s < 4; s++) begin
            repeat (19) @(negedge clk);
            do_step(cnt);
            total += cnt;
        end
        bus_if.btnUp = 1'b0;
        repeat (10) @(negedge clk);
        check("held_up_dir", int'(bus_if.dir), 0);
        check("held_up_strobes", total, 1);

        // Two 3-cycle glitches separated by a low gap never debounce.
        bus_if.btnLeft = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.btnLeft = 1'b0;
        repeat (2) @(negedge clk);
        bus_if.btnLeft = 1'b1;
        repeat (3) @(negedge clk);
        bus_if.btnLeft = 1'b0;
        repeat (12) @(negedge clk);
        do_step(cnt);
        check("glitch_dir", int'(bus_if.dir), 0);
        check("glitch_strobes", cnt, 0);

        // Press landing on the step cycle is checked against the newly committed dir.
        apply_dirs(4'b0010);
        bus_if.btnDown = 1'b1;
        repeat (6) @(negedge clk);
        do_step(cnt);
        check("same_cycle_commit_dir", int'(bus_if.dir), 2);
        check("same_cycle_commit_strobes", cnt, 1);
        bus_if.btnDown = 1'b0;
        repeat (10) @(negedge clk);
        do_step(cnt);
        check("same_cycle_new_pending_dir", int'(bus_if.dir), 1);
        check("same_cycle_new_pending_strobes", cnt, 1);

        // Pause with a pending direction: pending dropped, steps ignored.
        apply_dirs(4'b0010);
        press_start();
        check("pause_lock", int'(bus_if.lock), 1);
        total = 0;
        do_step(cnt);
        total += cnt;
        do_step(cnt);
        total += cnt;
        apply_dirs(4'b0001);
        do_step(cnt);
        total += cnt;
        check("pause_dir", int'(bus_if.dir), 1);
        check("pause_strobes", total, 0);
        press_start();
        check("resume_lock", int'(bus_if.lock), 0);
        do_step(cnt);
        check("resume_dir", int'(bus_if.dir), 1);
        check("resume_strobes", cnt, 0);

        // Reset in RUN with a pending direction.
        apply_dirs(4'b0010);
        reset = 1'b1;
        #1;
        check("midrun_reset_dir", int'(bus_if.dir), 3);
        check("midrun_reset_lock", int'(bus_if.lock), 1);
        check("midrun_reset_strobe", int'(bus_if.dirStrobe), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        total = 0;
        do_step(cnt);
        total += cnt;
        do_step(cnt);
        total += cnt;
        check("post_reset_dir", int'(bus_if.dir), 3);
        check("post_reset_strobes", total, 0);
        check("post_reset_lock", int'(bus_if.lock), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dir_input_ctrl.md
DIR_INPUT_CTRL -- requirements
Module: dir_input_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles before a debounced input changes.
REQ-002 clk  input  1  sole clock; all state on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 step  input  1  one-cycle game-update tick; commits pending direction.
REQ-005 start  input  1  raw start/pause push button, active-high, asynchronous to clk.
REQ-006 btnUp, btnDown, btnLeft, btnRight  input  1 each  raw direction buttons, active-high, asynchronous.
REQ-007 dir  output  2  committed direction: 00 up, 01 down, 10 left, 11 right.
REQ-008 dirStrobe  output  1  one-cycle pulse in the cycle after dir changes.
REQ-009 lock  output  1  high whenever game is not in RUN; freezes the movement stage.

Function
REQ-010 Each of the five raw inputs SHALL pass a 2-flop synchronizer before any other logic.
REQ-011 Debounce: stable value SHALL flip only after synced value differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-012 Press event SHALL be a rising edge of a debounced signal, one cycle wide.
REQ-013 FSM states IDLE, RUN, PAUSE; start press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; no other transitions.
REQ-014 lock SHALL be combinational (state != RUN).
REQ-015 Direction presses SHALL be ignored outside RUN; pending SHALL be cleared on leaving RUN.
REQ-016 Simultaneous direction presses SHALL resolve by priority Up > Down > Left > Right; only the winner is considered.
REQ-017 A press equal to, or opposite to (up/down, left/right), the direction dir holds after the current cycle SHALL be discarded.
REQ-018 An accepted press SHALL load pending and set pendingValid, overwriting any earlier pending value.
REQ-019 On step in RUN with pendingValid: dir <= pending, pendingValid cleared, dirStrobe high next cycle only.
REQ-020 step without pendingValid, or outside RUN, SHALL leave dir unchanged and dirStrobe low.
REQ-021 step and accepted press in the same cycle: step commits the old pending; new press is checked against the new dir and stored as pending.
REQ-022 Maximum response: press edge to dir change is bounded by the next step after 2+DEBOUNCE_CYCLES+1 cycles.
REQ-023 Debounce counters SHALL saturate-free wrap impossible: width ceil(log2(DEBOUNCE_CYCLES+1)).

Reset
REQ-024 On reset assertion, immediately: state IDLE, dir 11 (right), dirStrobe 0, lock 1, pendingValid 0.
REQ-025 Synchronizer flops, debounced values and counters SHALL reset to 0; edge detectors therefore see no press at deassertion if buttons are released.
REQ-026 Reset mid-debounce or mid-RUN SHALL discard all in-flight state; no strobe after deassertion.

Structure
REQ-027 Direction encodings and FSM state encodings SHALL live in shared package snake_pkg, used also by the movement stage.
REQ-028 Synchronizer+debouncer+edge detect SHALL be one sub-module btn_debounce, instantiated five times.

Verification (DEBOUNCE_CYCLES=4)
REQ-029 Reset, hold start high 10 cycles -> lock falls 7 cycles after start rise (2 sync + 4 debounce + edge), state RUN, dir=11.
REQ-030 RUN, dir=11, btnUp held, step every 20 cycles -> dir=00 at first step after press registers, one dirStrobe; no further strobes while held.
REQ-031 RUN, dir=11, btnLeft press -> discarded; next step: dir stays 11, no strobe.
REQ-032 btnUp glitch high 3 cycles then low -> no press, pending stays invalid.
REQ-033 btnDown and btnLeft debounced in same cycle with dir=11 -> Down wins; next step dir=01; Left never applied.
REQ-034 Pending valid, start pressed (->PAUSE), steps issued -> dir unchanged, lock=1; resume RUN, step -> still unchanged (pending cleared).
